// File: rtl/beat_step_timer.sv
// Beat/step timer: divides clk by (tempo+1) into one-cycle beat pulses that walk a
// step index around a measure, with play/pause/stop transport control.
module beat_step_timer #(
    parameter int TEMPO_W = 22,
    parameter int STEPS   = 8,
    parameter int STEP_W  = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               play_pulse,
    input  logic               stop_pulse,
    output logic               beat_pulse,
    output logic               measure_pulse,
    output logic [STEP_W-1:0]  step,
    output logic               running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t             state_q, state_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               beat_q, beat_d;
    logic               measure_q, measure_d;
    logic               running_q, running_d;
    logic [STEP_W-1:0]  step_nxt;

    assign step_nxt = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);

    // Live tempo compare with >= so a lowered tempo fires the pending beat at once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        step_d    = step_q;
        beat_d    = 1'b0;
        measure_d = 1'b0;

        if (stop_pulse) begin
            state_d = IDLE;
            cnt_d   = '0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d  = '0;
                    step_d = '0;
                    if (play_pulse) begin
                        state_d   = RUN;
                        beat_d    = 1'b1;
                        measure_d = 1'b1;
                    end
                end
                RUN: begin
                    // Pausing holds cnt even when a beat was due; it fires after resume.
                    if (play_pulse) begin
                        state_d = PAUSE;
                    end else if (cnt_q >= tempo) begin
                        cnt_d     = '0;
                        step_d    = step_nxt;
                        beat_d    = 1'b1;
                        measure_d = (step_nxt == '0);
                    end else begin
                        cnt_d = cnt_q + TEMPO_W'(1);
                    end
                end
                PAUSE: begin
                    if (play_pulse) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            step_q    <= '0;
            beat_q    <= 1'b0;
            measure_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            beat_q    <= beat_d;
            measure_q <= measure_d;
            running_q <= running_d;
        end
    end

    assign beat_pulse    = beat_q;
    assign measure_pulse = measure_q;
    assign step          = step_q;
    assign running       = running_q;

endmodule

// File: tb/tb_beat_step_timer.sv
// Scoreboard bench for beat_step_timer: directed transport sequences push the
// hand-derived beats (cycle, step, measure) that a negedge monitor pops and checks.
module tb_beat_step_timer;

    logic        clk;
    logic        n_rst;
    logic [21:0] tempo;
    logic        play_pulse;
    logic        stop_pulse;
    logic        beat_pulse;
    logic        measure_pulse;
    logic [2:0]  step;
    logic        running;

    typedef struct {
        int         cyc;
        logic [2:0] stp;
        logic       meas;
    } beat_t;

    beat_t expQ[$];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;

    beat_step_timer #(.TEMPO_W(22), .STEPS(8), .STEP_W(3)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tempo        (tempo),
        .play_pulse   (play_pulse),
        .stop_pulse   (stop_pulse),
        .beat_pulse   (beat_pulse),
        .measure_pulse(measure_pulse),
        .step         (step),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: inputs driven after a posedge belong to this cycle, and the
    // registered response to them is visible at the negedge of the next cycle.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkAt(input int target);
        waitCycle(target);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int atCycle, input logic playV, input logic stopV);
        waitCycle(atCycle);
        play_pulse = playV;
        stop_pulse = stopV;
        @(posedge clk);
        #1;
        play_pulse = 1'b0;
        stop_pulse = 1'b0;
    endtask

    task automatic expectBeat(input int c, input int s, input logic m);
        beat_t b;
        b.cyc  = c;
        b.stp  = 3'(s);
        b.meas = m;
        expQ.push_back(b);
    endtask

    // Monitor: every beat must match the oldest expectation; stray pulses are errors.
    always @(negedge clk) begin
        if (beat_pulse) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_beat: got beat at cycle %0d, expected none", cyc);
            end else begin
                beat_t b;
                b = expQ.pop_front();
                checkOutput("beat_cycle", cyc, b.cyc);
                checkOutput("beat_step", int'(step), int'(b.stp));
                checkOutput("beat_measure", int'(measure_pulse), int'(b.meas));
            end
        end else if (measure_pulse) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL measure_without_beat: got measure_pulse=1 at cycle %0d, expected 0", cyc);
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst      = 1'b0;
        tempo      = 22'd3;
        play_pulse = 1'b0;
        stop_pulse = 1'b0;

        // Reset state
        checkAt(3);
        checkOutput("rst_beat", int'(beat_pulse), 0);
        checkOutput("rst_measure", int'(measure_pulse), 0);
        checkOutput("rst_step", int'(step), 0);
        checkOutput("rst_running", int'(running), 0);
        waitCycle(4);
        n_rst = 1'b1;

        // tempo=3: downbeat one cycle after play, period 4, wrap after 8 steps
        for (int k = 0; k < 10; k++) expectBeat(7 + 4 * k, k % 8, (k % 8) == 0);
        applyStimulus(6, 1'b1, 1'b0);
        checkAt(8);
        checkOutput("run_running", int'(running), 1);
        checkOutput("run_step0", int'(step), 0);
        checkAt(12);
        checkOutput("run_step1_held", int'(step), 1);
        applyStimulus(46, 1'b0, 1'b1);
        checkAt(47);
        checkOutput("stop_running", int'(running), 0);
        checkOutput("stop_step", int'(step), 0);

        // Pause mid-beat, resume from held count
        expectBeat(51, 0, 1'b1);
        expectBeat(63, 1, 1'b0);
        expectBeat(67, 2, 1'b0);
        applyStimulus(50, 1'b1, 1'b0);
        applyStimulus(53, 1'b1, 1'b0);
        checkAt(55);
        checkOutput("pause_running", int'(running), 0);
        checkOutput("pause_step", int'(step), 0);
        applyStimulus(60, 1'b1, 1'b0);
        checkAt(62);
        checkOutput("resume_running", int'(running), 1);
        applyStimulus(68, 1'b0, 1'b1);
        checkAt(69);
        checkOutput("stop2_running", int'(running), 0);

        // Pause exactly when a beat is due: beat deferred to first cycle after resume
        expectBeat(73, 0, 1'b1);
        expectBeat(82, 1, 1'b0);
        expectBeat(86, 2, 1'b0);
        applyStimulus(72, 1'b1, 1'b0);
        applyStimulus(76, 1'b1, 1'b0);
        applyStimulus(80, 1'b1, 1'b0);
        applyStimulus(88, 1'b0, 1'b1);

        // tempo 9 -> 2 while cnt=7: beat next cycle, then every 3 cycles
        waitCycle(90);
        tempo = 22'd9;
        expectBeat(93, 0, 1'b1);
        expectBeat(101, 1, 1'b0);
        expectBeat(104, 2, 1'b0);
        expectBeat(107, 3, 1'b0);
        applyStimulus(92, 1'b1, 1'b0);
        waitCycle(100);
        tempo = 22'd2;
        applyStimulus(108, 1'b0, 1'b1);
        checkAt(109);
        checkOutput("stop3_running", int'(running), 0);

        // stop and play together at step 5: stop wins
        waitCycle(110);
        tempo = 22'd1;
        for (int k = 0; k < 6; k++) expectBeat(113 + 2 * k, k, k == 0);
        applyStimulus(112, 1'b1, 1'b0);
        applyStimulus(124, 1'b1, 1'b1);
        checkAt(125);
        checkOutput("stopplay_running", int'(running), 0);
        checkOutput("stopplay_step", int'(step), 0);
        expectBeat(128, 0, 1'b1);
        applyStimulus(127, 1'b1, 1'b0);
        applyStimulus(129, 1'b0, 1'b1);
        checkAt(130);
        checkOutput("stop4_running", int'(running), 0);

        // tempo=0: beat every cycle; reset mid-run clears everything
        waitCycle(132);
        tempo = 22'd0;
        for (int k = 0; k < 10; k++) expectBeat(135 + k, k % 8, (k % 8) == 0);
        applyStimulus(134, 1'b1, 1'b0);
        waitCycle(144);
        n_rst = 1'b0;
        checkAt(145);
        checkOutput("midrst_beat", int'(beat_pulse), 0);
        checkOutput("midrst_measure", int'(measure_pulse), 0);
        checkOutput("midrst_step", int'(step), 0);
        checkOutput("midrst_running", int'(running), 0);
        waitCycle(146);
        n_rst = 1'b1;
        checkAt(150);
        checkOutput("postrst_running", int'(running), 0);
        checkOutput("postrst_step", int'(step), 0);

        waitCycle(160);
        while (expQ.size() > 0) begin
            beat_t b;
            b = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL missing_beat: got no beat, expected beat at cycle %0d step %0d", b.cyc, b.stp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
